rnd_stream_source: RTL and testbench
====================================

Name: rnd_stream_source

Overview:
- Producer side of the RND/Finish interface: generates pseudo-random words on `Rnd_DO` for a downstream consumer, using a valid/ready handshake.
- Counts delivered words, then waits for the consumer's `Finish_SI` (with timeout) and reports completion or error.
- Sits between the test/config controller (`Start`, seed) and any RND-consuming datapath block.

Parameters:
- `RND_WIDTH`, 3, width of each random word; legal range 1..32.
- `NUM_WORDS`, 10, words delivered per run; must be ≥1.
- `DEFAULT_SEED`, 32'hACE1_0001, LFSR seed after reset; also replaces any zero seed.
- `FIN_TIMEOUT`, 64, maximum cycles to wait for `Finish_SI` after the last word; must be ≥1.

Ports:
- `CLK_CI`  input  1  clock; all state on rising edge.
- `Rst_RI`  input  1  asynchronous active-high reset.
- `Start_SI`  input  1  single-cycle pulse; starts a run when in IDLE or DONE.
- `SeedLoad_SI`  input  1  loads `Seed_DI` into the LFSR; honoured only in IDLE/DONE.
- `Seed_DI`  input  32  seed value.
- `Rnd_DO`  output  RND_WIDTH  current random word, equal to `lfsr[RND_WIDTH-1:0]`.
- `RndValid_SO`  output  1  `Rnd_DO` is valid.
- `RndReady_SI`  input  1  consumer accepts the word this cycle.
- `Finish_SI`  input  1  consumer has finished processing.
- `Done_SO`  output  1  run complete; level signal.
- `Error_SO`  output  1  run ended abnormally; valid while `Done_SO`=1.
- `Count_DO`  output  $clog2(NUM_WORDS+1)  number of words accepted in the current run.

Behaviour:
- Reset (async, any state): state=IDLE, `lfsr`=DEFAULT_SEED, `RndValid_SO`=0, `Done_SO`=0, `Error_SO`=0, `Count_DO`=0, timeout counter=0.
  - `Rnd_DO` = DEFAULT_SEED[RND_WIDTH-1:0].
- LFSR:
  - 32-bit Galois, right-shift, mask 32'h8020_0003 (x^32+x^22+x^2+x+1).
  - One step: `lfsr` ← (lfsr>>1) ^ (lfsr[0] ? mask : 0).
  - Steps only on an accepted handshake (`RndValid_SO` & `RndReady_SI`). Never steps otherwise.
- Seed load: in IDLE/DONE, `SeedLoad_SI`=1 sets `lfsr` ← `Seed_DI`, or DEFAULT_SEED if `Seed_DI`==0. Ignored in RUN/WAIT_FIN.
- Start and SeedLoad in the same cycle: the seed loads first; the run starts from the new seed next cycle.
- States:
  - IDLE:
    - `Start_SI` → RUN.
    - Clears `Count_DO`, `Done_SO` and `Error_SO` on the same edge.
  - RUN:
    - `RndValid_SO`=1 combinationally from state.
    - `Rnd_DO` holds stable while `RndReady_SI`=0.
    - On each handshake: `Count_DO`++ and LFSR steps.
    - Handshake with `Count_DO`==NUM_WORDS-1 → WAIT_FIN; timeout counter cleared.
    - `Finish_SI`=1 in RUN (early finish) → DONE with `Error_SO`=1. Any handshake in that same cycle is still counted.
  - WAIT_FIN:
    - `RndValid_SO`=0; counter increments each cycle.
    - `Finish_SI`=1 → DONE, `Error_SO`=0.
    - Counter reaching FIN_TIMEOUT-1 without `Finish_SI` → DONE, `Error_SO`=1.
    - `Finish_SI` on the timeout cycle counts as success.
  - DONE:
    - `Done_SO`=1 and `Error_SO` held; `Count_DO` held.
    - `Start_SI` → RUN, clearing `Done_SO`, `Error_SO` and `Count_DO`.
- `Start_SI` in RUN/WAIT_FIN is ignored.
- The LFSR is not reseeded between runs; consecutive runs continue the sequence.
- Latency:
  - `Start_SI` at edge N → `RndValid_SO`=1 after edge N.
  - With `RndReady_SI` tied high: NUM_WORDS words on consecutive cycles, then WAIT_FIN.
- `Count_DO` saturates at NUM_WORDS; no wrap.

Test Plan:
- Seed order: reset, `SeedLoad_SI` with `Seed_DI`=1, `Start_SI`, RND_WIDTH=2, `RndReady_SI`=1.
  - Required: accepted words 1, 3, 2, 1.
  - Required: `lfsr` sequence 0x00000001, 0x80200003, 0xC0300002, 0x60180001.
- Backpressure: RND_WIDTH=2, `RndReady_SI` toggles 0/1 every cycle.
  - Required: `Rnd_DO` stable during ready=0.
  - Required: exactly NUM_WORDS=10 handshakes, then `RndValid_SO`=0.
  - Required: `Count_DO`=10.
- Normal finish: `Finish_SI` pulse 5 cycles after the last word → `Done_SO`=1, `Error_SO`=0. Then `Start_SI` → `Done_SO`=0, `Count_DO`=0, and the LFSR continues from its last value.
- Timeout: no `Finish_SI`; exactly FIN_TIMEOUT=64 cycles after the last handshake, `Done_SO`=1 and `Error_SO`=1.
- Early finish and zero seed:
  - `Finish_SI` after 3 words → DONE, `Error_SO`=1, `Count_DO`=3.
  - `Seed_DI`=0 load → `lfsr`=DEFAULT_SEED.
- Async reset asserted mid-RUN with `RndValid_SO`=1 → all outputs return to reset values immediately, without waiting for a clock edge. A new `Start_SI` after release runs from DEFAULT_SEED.

Source files
------------

// File: rtl/rnd_stream_source.sv
// Producer side of the RND/Finish interface. The block delivers NUM_WORDS
// pseudo-random words over a valid/ready handshake. It then waits, with a
// timeout, for the consumer's Finish_SI and reports success or error.
module rnd_stream_source #(
    parameter int          RND_WIDTH    = 3,
    parameter int          NUM_WORDS    = 10,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE1_0001,
    parameter int          FIN_TIMEOUT  = 64
) (
    input  logic                                 CLK_CI,
    input  logic                                 Rst_RI,
    input  logic                                 Start_SI,
    input  logic                                 SeedLoad_SI,
    input  logic [31:0]                          Seed_DI,
    output logic [RND_WIDTH-1:0]                 Rnd_DO,
    output logic                                 RndValid_SO,
    input  logic                                 RndReady_SI,
    input  logic                                 Finish_SI,
    output logic                                 Done_SO,
    output logic                                 Error_SO,
    output logic [$clog2(NUM_WORDS+1)-1:0]       Count_DO
);

    localparam int              CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int              TMO_W     = $clog2(FIN_TIMEOUT + 1);
    localparam logic [31:0]     LFSR_MASK = 32'h8020_0003;  // x^32+x^22+x^2+x+1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_WORDS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      lfsr;
    logic [TMO_W-1:0] tmo;
    logic             handshake;
    logic             can_start;

    assign RndValid_SO = (state == S_RUN);
    assign Done_SO     = (state == S_DONE);
    assign Rnd_DO      = lfsr[RND_WIDTH-1:0];
    assign handshake   = RndValid_SO & RndReady_SI;
    // Seed loads and starts are only honoured while no run is in progress.
    assign can_start   = (state == S_IDLE) || (state == S_DONE);

    // State register.
    always_ff @(posedge CLK_CI or posedge Rst_RI) begin
        // NOTE: sequential state uses non-blocking assignments. All flops then
        // sample pre-edge values, whatever order the blocks are evaluated in.
        if (Rst_RI) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; early finish in RUN takes priority over the last word.
    always_comb begin
        // NOTE: default first, so that no path through the case infers a latch.
        state_next = state;
        case (state)
            S_IDLE:     if (Start_SI) state_next = S_RUN;
            S_RUN: begin
                if (Finish_SI)                                state_next = S_DONE;
                else if (handshake && (Count_DO == CNT_LAST)) state_next = S_WAIT_FIN;
            end
            S_WAIT_FIN: if (Finish_SI || (tmo == TMO_LAST)) state_next = S_DONE;
            S_DONE:     if (Start_SI) state_next = S_RUN;
            default:    state_next = S_IDLE;
        endcase
    end

    // LFSR: seed load when idle, one Galois step per accepted word.
    always_ff @(posedge CLK_CI or posedge Rst_RI) begin
        if (Rst_RI)                     lfsr <= DEFAULT_SEED;
        else if (can_start && SeedLoad_SI)
            lfsr <= (Seed_DI == 32'h0) ? DEFAULT_SEED : Seed_DI;
        else if (handshake)
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'h0);
    end

    // Accepted-word counter: cleared on start, saturates at NUM_WORDS.
    always_ff @(posedge CLK_CI or posedge Rst_RI) begin
        if (Rst_RI)                                Count_DO <= '0;
        else if (can_start && Start_SI)            Count_DO <= '0;
        else if (handshake && (Count_DO != CNT_MAX)) Count_DO <= Count_DO + 1'b1;
    end

    // Finish timeout counter: held at zero in RUN, counts while waiting.
    always_ff @(posedge CLK_CI or posedge Rst_RI) begin
        if (Rst_RI)                                       tmo <= '0;
        else if (state == S_RUN)                          tmo <= '0;
        else if ((state == S_WAIT_FIN) && (tmo != TMO_LAST)) tmo <= tmo + 1'b1;
    end

    // Error flag: set when DONE is entered by early finish or by timeout.
    always_ff @(posedge CLK_CI or posedge Rst_RI) begin
        if (Rst_RI)
            Error_SO <= 1'b0;
        else if (can_start && Start_SI)
            Error_SO <= 1'b0;
        else if ((state_next == S_DONE) && (state != S_DONE))
            Error_SO <= (state == S_RUN) || !Finish_SI;
    end

endmodule

// File: tb/tb_rnd_stream_source.sv
// Self-checking bench for rnd_stream_source. The stimulus pushes the expected
// words of each run into a scoreboard queue. A monitor pops that queue and
// compares on every accepted handshake.
module tb_rnd_stream_source;

    localparam int          RW   = 2;
    localparam int          NW   = 10;
    localparam int          FT   = 64;
    localparam logic [31:0] DS   = 32'hACE1_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam int          CW   = $clog2(NW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          seed_load;
    logic [31:0]   seed;
    logic [RW-1:0] rnd;
    logic          valid;
    logic          ready;
    logic          finish;
    logic          done;
    logic          error;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    rnd_stream_source #(
        .RND_WIDTH    (RW),
        .NUM_WORDS    (NW),
        .DEFAULT_SEED (DS),
        .FIN_TIMEOUT  (FT)
    ) dut (
        .CLK_CI      (clk),
        .Rst_RI      (rst),
        .Start_SI    (start),
        .SeedLoad_SI (seed_load),
        .Seed_DI     (seed),
        .Rnd_DO      (rnd),
        .RndValid_SO (valid),
        .RndReady_SI (ready),
        .Finish_SI   (finish),
        .Done_SO     (done),
        .Error_SO    (error),
        .Count_DO    (count)
    );

    typedef struct {
        logic [RW-1:0] word;
        logic [31:0]   state;
    } exp_t;

    exp_t          exp_q[$];
    logic [31:0]   acc_state_q[$];
    logic [RW-1:0] acc_word_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            hs_count = 0;
    logic [31:0]   m_lfsr;
    logic          hold_pend = 1'b0;
    logic [RW-1:0] hold_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference LFSR step, taken directly from the polynomial definition.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? POLY : 32'h0);
    endfunction

    // Monitor: checks every accepted word and word stability under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && valid) check("hold_stable", 32'(rnd), 32'(hold_word));
            hold_pend = valid && !ready;
            hold_word = rnd;
            if (valid && ready) begin
                hs_count++;
                acc_state_q.push_back(dut.lfsr);
                acc_word_q.push_back(rnd);
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rnd_word", 32'(rnd), 32'(e.word));
                    check("lfsr_state", dut.lfsr, e.state);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected words for a full run, computed from the model LFSR.
    task automatic push_run();
        logic [31:0] t;
        exp_t        e;
        t = m_lfsr;
        for (int i = 0; i < NW; i++) begin
            e.word  = t[RW-1:0];
            e.state = t;
            exp_q.push_back(e);
            t = lfsr_next(t);
        end
    endtask

    // Close a run in the model: advance by the accepted words and drop the rest.
    task automatic finish_model(input int accepted);
        check("queue_leftover", 32'(exp_q.size()), 32'(NW - accepted));
        for (int i = 0; i < accepted; i++) m_lfsr = lfsr_next(m_lfsr);
        exp_q.delete();
    endtask

    // Drive ready (0: high, 1: toggle, 2: random) until n more handshakes occur.
    task automatic run_words(input int n, input int mode);
        int base;
        int budget;
        base   = hs_count;
        budget = 2000;
        while ((hs_count - base < n) && (budget > 0)) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if ($urandom_range(0, 7) == 0) start = 1'b1;  // ignored while running
            tick();
            start  = 1'b0;
            budget--;
        end
        ready = 1'b0;
        if (budget == 0) check("run_words_budget", 32'(hs_count - base), 32'(n));
    endtask

    task automatic do_start();
        start = 1'b1;
        push_run();
        tick();
        start = 1'b0;
        check("start_valid", 32'(valid), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_count", 32'(count), 32'd0);
    endtask

    task automatic pulse_finish_after(input int delay);
        for (int i = 0; i < delay; i++) tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] seq_state [4];
        logic [31:0] seq_word  [4];
        seq_state = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
        seq_word  = '{32'd1, 32'd3, 32'd2, 32'd1};

        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0;
        ready = 1'b0; finish = 1'b0;
        m_lfsr = DS;
        #12;
        check("rst_rnd", 32'(rnd), 32'(DS[RW-1:0]));
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Seed 1 loaded in the same cycle as Start, ready held high.
        seed_load = 1'b1; seed = 32'h1;
        m_lfsr = 32'h1;
        acc_state_q.delete(); acc_word_q.delete();
        do_start();
        seed_load = 1'b0;
        run_words(NW, 0);
        for (int i = 0; i < 4; i++) begin
            check("seed1_state", acc_state_q[i], seq_state[i]);
            check("seed1_word", 32'(acc_word_q[i]), seq_word[i]);
        end
        finish_model(NW);
        check("full_valid_low", 32'(valid), 32'd0);
        check("full_count", 32'(count), 32'(NW));
        // Normal finish 5 cycles after the last word; a stray Start is ignored.
        tick(); start = 1'b1; tick(); start = 1'b0;
        pulse_finish_after(3);
        check("norm_done", 32'(done), 32'd1);
        check("norm_error", 32'(error), 32'd0);
        check("norm_count", 32'(count), 32'(NW));

        // Backpressure run from DONE; a seed load during RUN must be ignored.
        do_start();
        seed_load = 1'b1; seed = 32'h1234_5678;
        tick();
        seed_load = 1'b0;
        k = hs_count;
        run_words(NW, 1);
        check("bp_handshakes", 32'(hs_count - k), 32'(NW));
        finish_model(NW);
        check("bp_valid_low", 32'(valid), 32'd0);
        check("bp_count", 32'(count), 32'(NW));
        // Timeout: no Finish, count cycles from the last handshake to Done.
        k = 0;
        while (!done && (k < 4 * FT)) begin
            tick();
            k++;
        end
        check("timeout_cycles", 32'(k), 32'(FT));
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_count", 32'(count), 32'(NW));

        // Early finish sharing its cycle with the third handshake.
        do_start();
        run_words(2, 2);
        ready = 1'b1; finish = 1'b1;
        tick();
        ready = 1'b0; finish = 1'b0;
        finish_model(3);
        check("early_done", 32'(done), 32'd1);
        check("early_error", 32'(error), 32'd1);
        check("early_count", 32'(count), 32'd3);

        // Zero seed falls back to the default seed.
        seed_load = 1'b1; seed = 32'h0;
        tick();
        seed_load = 1'b0;
        m_lfsr = DS;
        check("zero_seed_lfsr", dut.lfsr, DS);
        check("zero_seed_rnd", 32'(rnd), 32'(DS[RW-1:0]));

        // Random seeds, random ready, random finish delay.
        for (int r = 0; r < 3; r++) begin
            seed_load = 1'b1; seed = $urandom();
            if (r == 0) seed = 32'h0;
            tick();
            seed_load = 1'b0;
            m_lfsr = (seed == 32'h0) ? DS : seed;
            check("rand_seed_lfsr", dut.lfsr, m_lfsr);
            do_start();
            run_words(NW, 2);
            finish_model(NW);
            pulse_finish_after($urandom_range(0, 10));
            check("rand_done", 32'(done), 32'd1);
            check("rand_error", 32'(error), 32'd0);
        end

        // Asynchronous reset in the middle of a run.
        do_start();
        run_words(4, 0);
        ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_rnd", 32'(rnd), 32'(DS[RW-1:0]));
        ready = 1'b0;
        exp_q.delete();
        m_lfsr = DS;
        tick();
        rst = 1'b0;
        tick();
        do_start();
        run_words(NW, 2);
        finish_model(NW);
        pulse_finish_after(1);
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_error", 32'(error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
